ifetch: RTL and testbench

Instruction-fetch stage of the RV32 core. It owns the architectural PC and issues word requests to instruction memory over a request/grant/response handshake. It presents each fetched instruction with its PC to decode under a valid/ready handshake. It sits directly upstream of decode and consumes the redirect target produced by the branch/jump resolution block; sequential PC+4 is generated internally.

---
 rtl/ifetch_pkg.sv | 15 +
 rtl/ifetch_adder32.sv | 13 +
 rtl/ifetch.sv | 153 +++++++++++++++
 tb/tb_ifetch.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
package ifetch_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StHold
  } ifetch_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/ifetch_adder32.sv
// Plain 32-bit adder with carry in/out.
module ifetch_adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  // Widen to 33 bits so the carry falls out of the top bit.
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'b0, cin};

endmodule

// File: rtl/ifetch.sv
// Instruction-fetch stage: owns the PC, fetches one word at a time from
// instruction memory and hands it to decode under valid/ready.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_misalign
);

  ifetch_state_e state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic          kill_q, kill_d;
  logic [31:0]   out_pc_q, out_instr_q;
  logic          out_misalign_q;
  logic          load_data, load_misalign;
  logic [31:0]   pc_plus4;
  logic          unused_carry;
  logic          misaligned;

  assign misaligned = |pc_q[1:0];

  ifetch_adder32 u_pc_adder (
    .a    (pc_q),
    .b    (32'd4),
    .cin  (1'b0),
    .sum  (pc_plus4),
    .cout (unused_carry)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, next PC, kill tracking and output-buffer load strobes.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    kill_d        = kill_q;
    load_data     = 1'b0;
    load_misalign = 1'b0;

    unique case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        if (misaligned) begin
          load_misalign = 1'b1;
          state_d       = StHold;
        end else if (imem_gnt) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (imem_rvalid) begin
          kill_d = 1'b0;
          if (kill_q) begin
            state_d = StReq;
          end else begin
            load_data = 1'b1;
            state_d   = StHold;
          end
        end
      end
      StHold: begin
        if (out_ready) begin
          pc_d    = pc_plus4;
          state_d = StReq;
        end
      end
      default: state_d = StIdle;
    endcase

    // Redirect overrides everything; a request already granted must have
    // its response swallowed, so kill stays armed until that rvalid arrives.
    if (redirect_en) begin
      pc_d          = redirect_pc;
      load_data     = 1'b0;
      load_misalign = 1'b0;
      unique case (state_q)
        StReq: begin
          if (!misaligned && imem_gnt) begin
            kill_d  = 1'b1;
            state_d = StWait;
          end else begin
            state_d = StReq;
          end
        end
        StWait: begin
          if (imem_rvalid) begin
            kill_d  = 1'b0;
            state_d = StReq;
          end else begin
            kill_d  = 1'b1;
            state_d = StWait;
          end
        end
        default: state_d = StReq;
      endcase
    end
  end

  // PC, kill flag and the instruction buffer presented to decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q           <= RESET_PC;
      kill_q         <= 1'b0;
      out_pc_q       <= 32'h0;
      out_instr_q    <= 32'h0;
      out_misalign_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      kill_q <= kill_d;
      if (load_data) begin
        out_pc_q       <= pc_q;
        out_instr_q    <= imem_rdata;
        out_misalign_q <= 1'b0;
      end else if (load_misalign) begin
        out_pc_q       <= pc_q;
        out_instr_q    <= NOP_INSTR;
        out_misalign_q <= 1'b1;
      end
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    imem_req     = (state_q == StReq) && !misaligned;
    imem_addr    = pc_q;
    out_valid    = (state_q == StHold);
    out_pc       = out_pc_q;
    out_instr    = out_instr_q;
    out_misalign = out_misalign_q;
  end

endmodule

// File: tb/tb_ifetch.sv
// Randomized scoreboard bench for ifetch.
module tb_ifetch;
  import ifetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          NUM_CYCLES = 4000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_misalign;

  ifetch #(.RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .redirect_en  (redirect_en),
    .redirect_pc  (redirect_pc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_instr    (out_instr),
    .out_misalign (out_misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Driver-side model state.
  logic [31:0] model_pc;
  bit          pend = 1'b0;
  logic [31:0] pend_addr;
  int          pend_cnt;
  int          stall_cnt = 0;
  bit          do_accept = 1'b0;
  bit          do_redirect = 1'b0;
  logic [31:0] rd_target;
  bit          active = 1'b0;
  bit          zero_wait = 1'b0;
  bit          rst_done = 1'b0;
  int          cyc = 0;

  // Monitor-side history.
  bit          prev_valid, prev_ready, prev_redirect;
  logic [31:0] prev_pc, prev_instr;
  int          idle_cnt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  function automatic exp_t make_exp(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.mis   = (pc[1:0] != 2'b00);
    e.instr = e.mis ? NOP_INSTR : mem_word(pc);
    return e;
  endfunction

  function automatic logic [31:0] pick_target();
    logic [31:0] t;
    int          sel;
    t   = $urandom & 32'h0000_0FFC;
    sel = $urandom_range(0, 7);
    if (sel == 0) t = 32'hFFFF_FFF8;
    if (sel == 1) t = 32'hFFFF_FFFC;
    if (sel == 2) t = t | 32'($urandom_range(1, 3));
    return t;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset();
    check1("rst_imem_req", imem_req, 1'b0);
    check32("rst_imem_addr", imem_addr, RST_PC);
    check1("rst_out_valid", out_valid, 1'b0);
    check32("rst_out_pc", out_pc, 32'h0);
    check32("rst_out_instr", out_instr, 32'h0);
    check1("rst_out_misalign", out_misalign, 1'b0);
  endtask

  task automatic release_reset();
    rst_n    = 1'b1;
    model_pc = RST_PC;
    exp_q.delete();
    exp_q.push_back(make_exp(RST_PC));
    cyc         = 0;
    do_accept   = 1'b0;
    do_redirect = 1'b0;
    active      = 1'b1;
  endtask

  // Decide all inputs for the current cycle; called just after the clock edge.
  task automatic drive_cycle(input int c);
    bit gnt_now;
    zero_wait = (c < 12);
    check1("req_while_pending", imem_req & pend, 1'b0);

    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (pend) begin
      if (pend_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend_addr);
        pend        = 1'b0;
      end else begin
        pend_cnt--;
      end
    end

    gnt_now  = zero_wait ? 1'b1 : ($urandom_range(0, 2) != 0);
    imem_gnt = gnt_now;
    if (imem_req && gnt_now) begin
      pend      = 1'b1;
      pend_addr = imem_addr;
      pend_cnt  = zero_wait ? 0 : int'($urandom_range(0, 2));
    end else if (!zero_wait && !imem_rvalid && !pend && $urandom_range(0, 15) == 0) begin
      imem_rvalid = 1'b1;  // stray response, must be ignored
    end

    if (zero_wait) begin
      out_ready = 1'b1;
    end else begin
      if (stall_cnt == 0 && $urandom_range(0, 30) == 0) stall_cnt = 6;
      if (stall_cnt > 0) begin
        out_ready = 1'b0;
        stall_cnt--;
      end else begin
        out_ready = ($urandom_range(0, 2) != 0);
      end
    end

    redirect_en = 1'b0;
    redirect_pc = $urandom;
    if (!zero_wait && $urandom_range(0, 11) == 0) begin
      redirect_en = 1'b1;
      redirect_pc = pick_target();
    end

    do_redirect = redirect_en;
    rd_target   = redirect_pc;
    do_accept   = out_valid && out_ready && !redirect_en;
  endtask

  // Stimulus and reference model.
  initial begin
    redirect_en = 1'b0;
    redirect_pc = 32'h0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    out_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset();
    release_reset();
    drive_cycle(0);
    for (int c = 1; c < NUM_CYCLES; c++) begin
      @(posedge clk);
      cyc++;
      if (do_redirect) begin
        model_pc = rd_target;
        exp_q.delete();
        exp_q.push_back(make_exp(model_pc));
      end else if (do_accept) begin
        model_pc = model_pc + 32'd4;
        exp_q.push_back(make_exp(model_pc));
      end
      #1;
      if (!rst_done && c >= 2000 && pend) begin
        rst_done    = 1'b1;
        rst_n       = 1'b0;
        active      = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        redirect_en = 1'b0;
        out_ready   = 1'b0;
        #1;
        check_reset();
        repeat (2) @(posedge clk);
        #1;
        release_reset();
        pend_cnt = 0;  // stale response shows up right after release
      end
      drive_cycle(c);
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Monitor: checks DUT outputs mid-cycle against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!active) begin
      prev_valid    <= 1'b0;
      prev_ready    <= 1'b0;
      prev_redirect <= 1'b0;
      idle_cnt      <= 0;
    end else begin
      if (imem_req) begin
        if (exp_q.size() == 0) begin
          check1("req_without_expected", imem_req, 1'b0);
        end else begin
          check32("imem_addr", imem_addr, exp_q[0].pc);
        end
      end
      if (exp_q.size() != 0 && exp_q[0].mis) check1("no_req_misaligned", imem_req, 1'b0);
      if (out_valid) check1("req_in_hold", imem_req, 1'b0);

      if (prev_valid && !prev_ready && !prev_redirect) begin
        check1("stall_valid", out_valid, 1'b1);
        check32("stall_pc", out_pc, prev_pc);
        check32("stall_instr", out_instr, prev_instr);
      end
      if (prev_valid && (prev_redirect || prev_ready)) check1("drop_valid", out_valid, 1'b0);
      if (zero_wait) check1("zero_wait_valid", out_valid, (cyc >= 3) && (cyc % 3 == 0));

      if (out_valid && out_ready && !redirect_en) begin
        if (exp_q.size() == 0) begin
          check1("unexpected_output", out_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check32("out_pc", out_pc, e.pc);
          check32("out_instr", out_instr, e.instr);
          check1("out_misalign", out_misalign, e.mis);
        end
        idle_cnt <= 0;
      end else if (idle_cnt >= 200) begin
        check1("delivery_timeout", 1'b0, 1'b1);
        idle_cnt <= 0;
      end else begin
        idle_cnt <= idle_cnt + 1;
      end

      prev_valid    <= out_valid;
      prev_ready    <= out_ready;
      prev_redirect <= redirect_en;
      prev_pc       <= out_pc;
      prev_instr    <= out_instr;
    end
  end

endmodule
